// File: rtl/grid_pkg.sv
// Purpose: shared grid geometry, pixel byte value and FSM state encoding for grid_streamer.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package grid_pkg;

    localparam int         GRID_SIZE  = 28;
    localparam int         NUM_PIXELS = GRID_SIZE * GRID_SIZE;   // 784
    localparam logic [9:0] LAST_INDEX = 10'(NUM_PIXELS - 1);     // 783
    localparam logic [7:0] ON_VALUE   = 8'd255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        SEND  = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/grid_streamer.sv
// Purpose: scans a GRID_SIZE x GRID_SIZE 1-bit pixel memory and streams one byte per pixel.
// Latency: 3 cycles per pixel minimum (FETCH, WAIT, SEND); a full frame takes 2352 cycles start-to-done.
// Backpressure: px_valid/px_ready; SEND holds data, index and last stable until the handshake.
//
// Ports:
//   CLOCK_50, resetn (async, active-low)
//   start / abort        : scan request pulse / scan termination
//   rd_addr, rd_data     : pixel memory read port, data valid one cycle after address
//   px_valid, px_ready, px_data, px_index, px_last : output pixel stream
//   busy, done, ink_count: status; ink_count = set pixels in the last completed frame
// Option: define GRID_STREAMER_INK_COUNT_EN to build the set-pixel counter;
//         otherwise ink_count is tied to zero.
module grid_streamer #(
    parameter int         GRID_SIZE = grid_pkg::GRID_SIZE,
    parameter logic [7:0] ON_VALUE  = grid_pkg::ON_VALUE
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       start,
    input  logic       abort,
    output logic [9:0] rd_addr,
    input  logic       rd_data,
    output logic       px_valid,
    input  logic       px_ready,
    output logic [7:0] px_data,
    output logic [9:0] px_index,
    output logic       px_last,
    output logic       busy,
    output logic       done,
    output logic [9:0] ink_count
);
    import grid_pkg::*;

    localparam logic [9:0] LAST_IDX = 10'(GRID_SIZE * GRID_SIZE - 1);

    state_t     state;
    state_t     state_nxt;
    logic [9:0] index;
    logic [7:0] pix_q;
    logic       hshk;

    // Handshake only counts while abort is low: abort wins over the final beat.
    assign hshk = (state == SEND) && px_ready && !abort;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_addr   = 10'd0;
        px_valid  = 1'b0;
        px_last   = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                rd_addr   = index;
                busy      = 1'b1;
                state_nxt = abort ? IDLE : WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                state_nxt = abort ? IDLE : SEND;
            end
            SEND: begin
                busy     = 1'b1;
                px_valid = 1'b1;
                px_last  = (index == LAST_IDX);
                if (abort) begin
                    state_nxt = IDLE;
                end else if (px_ready) begin
                    state_nxt = (index == LAST_IDX) ? DONE : FETCH;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Index and pixel byte. Index stops at LAST_IDX; the frame ends there.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            index <= 10'd0;
            pix_q <= 8'd0;
        end else begin
            if (state == IDLE && start && !abort) begin
                index <= 10'd0;
            end
            if (state == WAIT && !abort) begin
                pix_q <= rd_data ? ON_VALUE : 8'd0;
            end
            if (hshk && index != LAST_IDX) begin
                index <= index + 10'd1;
            end
        end
    end

    assign px_data  = pix_q;
    assign px_index = index;

`ifdef GRID_STREAMER_INK_COUNT_EN
    logic [9:0] run_count;
    logic       px_set;
    logic [9:0] ink_q;

    // Running count is only published on DONE, so aborted or reset scans
    // never disturb the last completed frame's value.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            run_count <= 10'd0;
            px_set    <= 1'b0;
            ink_q     <= 10'd0;
        end else begin
            if (state == IDLE && start && !abort) begin
                run_count <= 10'd0;
            end
            if (state == WAIT) begin
                px_set <= rd_data;
            end
            if (hshk && px_set) begin
                run_count <= run_count + 10'd1;
            end
            if (state == DONE) begin
                ink_q <= run_count;
            end
        end
    end

    assign ink_count = ink_q;
`else
    assign ink_count = 10'd0;
`endif

endmodule
